dp_ram_fifo_ctrl: RTL and testbench

DP_RAM_FIFO_CTRL -- requirements
Module: dp_ram_fifo_ctrl

---
 rtl/dp_ram_fifo_ctrl.sv | 99 +++++++++
 tb/tb_dp_ram_fifo_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM with 1-cycle read latency.
// Ports: clk_in/rst_n_in, clear, push/pop requests, status, RAM port.
module dp_ram_fifo_ctrl #(
  parameter int addr_width = 8,
  parameter int data_width = 32,
  parameter int af_level   = 2**addr_width-2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  clear,
  input  logic                  push_req,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop_req,
  output logic [data_width-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  output logic [addr_width-1:0] ram_wr_addr,
  output logic [addr_width-1:0] ram_rd_addr,
  output logic [data_width-1:0] ram_data_in,
  input  logic [data_width-1:0] ram_data_out
);

  localparam int PW = addr_width + 1;
  localparam logic [addr_width:0] AF_LVL =
    PW'(af_level);

  logic [addr_width:0] r_wr_ptr;
  logic [addr_width:0] r_rd_ptr;
  logic                r_pop_valid;
  logic                r_ovf;
  logic                r_udf;

  logic w_push_acc;
  logic w_pop_acc;
  logic w_full;
  logic w_empty;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  =
    (r_wr_ptr[addr_width] != r_rd_ptr[addr_width]) &&
    (r_wr_ptr[addr_width-1:0] ==
     r_rd_ptr[addr_width-1:0]);

  // rst_n_in gates the enables so the RAM sees no
  // strobes while the pointers are held in reset.
  assign w_push_acc =
    rst_n_in & push_req & ~w_full & ~clear;
  assign w_pop_acc  =
    rst_n_in & pop_req & ~w_empty & ~clear;

  assign ram_wr_en   = w_push_acc;
  assign ram_rd_en   = w_pop_acc;
  assign ram_wr_addr = r_wr_ptr[addr_width-1:0];
  assign ram_rd_addr = r_rd_ptr[addr_width-1:0];
  assign ram_data_in = push_data;

  assign pop_data    = ram_data_out;
  assign pop_valid   = r_pop_valid;
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_wr_ptr - r_rd_ptr;
  assign almost_full = (count >= AF_LVL);
  assign overflow    = r_ovf;
  assign underflow   = r_udf;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pop_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pop_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      if (w_push_acc)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_pop_valid <= w_pop_acc;
      if (push_req && w_full)
        r_ovf <= 1'b1;
      if (pop_req && w_empty)
        r_udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Scoreboard bench for dp_ram_fifo_ctrl (depth 4, af_level 2).
// Includes a behavioural 1-cycle-latency RAM.
module tb_dp_ram_fifo_ctrl;

  localparam int AW = 2;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          clear;
  logic          push_req;
  logic [DW-1:0] push_data;
  logic          pop_req;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          ram_wr_en;
  logic          ram_rd_en;
  logic [AW-1:0] ram_wr_addr;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem[4];
  logic [DW-1:0] vals[6];

  dp_ram_fifo_ctrl #(
    .addr_width(AW),
    .data_width(DW),
    .af_level(2)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .clear(clear),
    .push_req(push_req),
    .push_data(push_data),
    .pop_req(pop_req),
    .pop_data(pop_data),
    .pop_valid(pop_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .ram_wr_en(ram_wr_en),
    .ram_rd_en(ram_rd_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_rd_addr(ram_rd_addr),
    .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (ram_wr_en)
      mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_en)
      ram_data_out <= mem[ram_rd_addr];
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  // Monitor: every pop_valid strobe consumes one
  // expected word queued by the stimulus.
  always @(negedge clk_in) begin
    if (rst_n_in === 1'b1 && pop_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_valid_unexpected got=%0h exp=none",
                 pop_data);
      end else begin
        chk("pop_data", pop_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set(input logic p,
                     input logic [DW-1:0] d,
                     input logic q,
                     input logic c);
    push_req  = p;
    push_data = d;
    pop_req   = q;
    clear     = c;
  endtask

  task automatic idle;
    set(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vals[0] = 32'h1111_0000;
    vals[1] = 32'h2222_0001;
    vals[2] = 32'h3333_0002;
    vals[3] = 32'h4444_0003;
    vals[4] = 32'h5555_0004;
    vals[5] = 32'h6666_0005;

    // Reset with a push request pending.
    rst_n_in = 1'b0;
    set(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    #3;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    tick;
    idle;
    rst_n_in = 1'b1;
    tick;

    // Fill A..D.
    for (int i = 0; i < 4; i++) begin
      set(1'b1, vals[i], 1'b0, 1'b0);
      @(negedge clk_in);
      chk("fill_wr_en", ram_wr_en, 1);
      chk("fill_wr_addr", ram_wr_addr, i);
      chk("fill_din", ram_data_in, vals[i]);
      chk("fill_count", count, i);
      chk("fill_af", almost_full, i >= 2);
      tick;
    end
    idle;
    @(negedge clk_in);
    chk("full_flag", full, 1);
    chk("full_count", count, 4);
    chk("full_af", almost_full, 1);
    tick;

    // Drain A..D.
    for (int i = 0; i < 4; i++) begin
      set(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk_in);
      chk("drain_rd_en", ram_rd_en, 1);
      chk("drain_rd_addr", ram_rd_addr, i);
      exp_q.push_back(vals[i]);
      tick;
    end
    idle;
    @(negedge clk_in);
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    tick;

    // Clear to restart pointers at 0.
    set(1'b0, '0, 1'b0, 1'b1);
    tick;
    idle;

    // Wrap-around with paired push/pop.
    for (int i = 0; i < 7; i++) begin
      set(i < 6, (i < 6) ? vals[i % 6] : '0,
          i > 0, 1'b0);
      @(negedge clk_in);
      if (i < 6)
        chk("wrap_wr_addr", ram_wr_addr, i % 4);
      if (i > 0) begin
        chk("wrap_rd_addr", ram_rd_addr, (i - 1) % 4);
        exp_q.push_back(vals[i - 1]);
      end
      chk("wrap_full", full, 0);
      chk("wrap_count", count, (i > 0) ? 1 : 0);
      tick;
    end
    idle;
    @(negedge clk_in);
    chk("wrap_end_empty", empty, 1);

    // Pop while empty.
    tick;
    set(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk_in);
    chk("udf_rd_en", ram_rd_en, 0);
    tick;
    idle;
    @(negedge clk_in);
    chk("udf_flag", underflow, 1);
    chk("udf_pop_valid", pop_valid, 0);
    tick;

    // Fill, then push while full.
    for (int i = 0; i < 4; i++) begin
      set(1'b1, vals[i + 2], 1'b0, 1'b0);
      tick;
    end
    set(1'b1, 32'hBAD0_0000, 1'b0, 1'b0);
    @(negedge clk_in);
    chk("ovf_wr_en", ram_wr_en, 0);
    tick;
    idle;
    @(negedge clk_in);
    chk("ovf_flag", overflow, 1);
    tick;
    @(negedge clk_in);
    chk("ovf_sticky", overflow, 1);
    chk("udf_sticky", underflow, 1);
    chk("ovf_count", count, 4);

    // Push and pop together while full.
    tick;
    set(1'b1, 32'hBAD0_0001, 1'b1, 1'b0);
    @(negedge clk_in);
    chk("pf_wr_en", ram_wr_en, 0);
    chk("pf_rd_en", ram_rd_en, 1);
    exp_q.push_back(vals[2]);
    tick;
    idle;
    @(negedge clk_in);
    chk("pf_count", count, 3);
    chk("pf_ovf", overflow, 1);

    // Clear beats a push at count 3.
    tick;
    set(1'b1, 32'hBAD0_0002, 1'b0, 1'b1);
    @(negedge clk_in);
    chk("clr_wr_en", ram_wr_en, 0);
    chk("clr_rd_en", ram_rd_en, 0);
    tick;
    idle;
    @(negedge clk_in);
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);

    // Push and pop together while empty.
    tick;
    set(1'b1, vals[5], 1'b1, 1'b0);
    @(negedge clk_in);
    chk("pe_wr_en", ram_wr_en, 1);
    chk("pe_rd_en", ram_rd_en, 0);
    tick;
    idle;
    @(negedge clk_in);
    chk("pe_count", count, 1);
    chk("pe_udf", underflow, 1);
    chk("pe_pop_valid", pop_valid, 0);

    // Async reset with a pop in flight.
    tick;
    set(1'b1, vals[4], 1'b0, 1'b0);
    tick;
    set(1'b0, '0, 1'b1, 1'b0);
    tick;
    idle;
    rst_n_in = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_pop_valid", pop_valid, 0);
    chk("arst_udf", underflow, 0);
    #2;
    rst_n_in = 1'b1;
    tick;
    set(1'b1, vals[3], 1'b0, 1'b0);
    @(negedge clk_in);
    chk("post_rst_pv", pop_valid, 0);
    chk("post_rst_addr", ram_wr_addr, 0);
    tick;
    set(1'b0, '0, 1'b1, 1'b0);
    exp_q.push_back(vals[3]);
    tick;
    idle;
    tick;
    tick;
    chk("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
